// File: rtl/fifo_rr_arbiter.sv
// Round-robin read scheduler draining NUM_IN upstream fifos into one downstream fifo.
// Pops are combinational on the grant; the popped word is forwarded one cycle later.
module fifo_rr_arbiter #(
   parameter int unsigned NUM_IN     = 4,
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic [NUM_IN-1:0]              in_empty,
   input  logic [NUM_IN*DATA_WIDTH-1:0]   in_data,
   output logic [NUM_IN-1:0]              in_rd_en,
   input  logic                           out_full,
   input  logic                           out_almost_full,
   input  logic                           out_almost_empty,
   input  logic                           out_empty,
   output logic                           out_wr_en,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic [1:0]                     state,
   output logic [$clog2(NUM_IN)-1:0]      grant,
   output logic [7:0]                     xfer_count
);

   localparam int unsigned GW = $clog2(NUM_IN);
   localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      PAUSE  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [BW-1:0]         burst_q, burst_d;
   logic [GW-1:0]         sel_q;
   logic                  wr_q;
   logic [7:0]            xfer_q;
   logic                  stop;
   logic                  resume;
   logic                  any_req;
   logic                  pop;
   logic [DATA_WIDTH-1:0] lane_data [NUM_IN];

   // First non-empty lane at or after start (inclusive) or strictly after it; holds start if none.
   function automatic logic [GW-1:0] find_lane(input logic [GW-1:0]     start,
                                                input logic [NUM_IN-1:0] empty,
                                                input logic              inclusive);
      logic [GW-1:0] res;
      logic          found;
      int unsigned   idx;
      res   = start;
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         idx = (32'(start) + k) % NUM_IN;
         if (!found && (inclusive || (k != 0)) && !empty[idx]) begin
            res   = GW'(idx);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   assign stop    = out_full | out_almost_full;
   assign resume  = !stop & (out_almost_empty | out_empty);
   assign any_req = |(~in_empty);
   assign pop     = |in_rd_en;

   always_comb begin
      in_rd_en = '0;
      if ((state_q == ACTIVE) && en && !in_empty[grant_q] && !stop) begin
         in_rd_en[grant_q] = 1'b1;
      end
   end

   // Next-state, grant rotation and burst accounting
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      burst_d = burst_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_d = ACTIVE;
                  grant_d = find_lane(grant_q, in_empty, 1'b1);
                  burst_d = '0;
               end
            end
            ACTIVE: begin
               if (stop) begin
                  state_d = PAUSE;
               end else if (!any_req) begin
                  state_d = IDLE;
               end else if (pop && (burst_q == BW'(MAX_BURST - 1))) begin
                  grant_d = find_lane(grant_q, in_empty, 1'b0);
                  burst_d = '0;
               end else if (pop) begin
                  burst_d = burst_q + BW'(1);
               end else begin
                  grant_d = find_lane(grant_q, in_empty, 1'b0);
                  burst_d = '0;
               end
            end
            PAUSE: begin
               if (resume) begin
                  state_d = ACTIVE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         burst_q <= burst_d;
      end
   end

   // One-cycle forwarding of the popped word plus the write counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q   <= 1'b0;
         sel_q  <= '0;
         xfer_q <= '0;
      end else begin
         wr_q <= pop;
         if (pop) begin
            sel_q <= grant_q;
         end
         if (wr_q) begin
            xfer_q <= xfer_q + 8'd1;
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         lane_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      out_data = '0;
      if (wr_q) begin
         out_data = lane_data[sel_q];
      end
   end

   assign out_wr_en  = wr_q;
   assign state      = state_q;
   assign grant      = grant_q;
   assign xfer_count = xfer_q;

endmodule
